score_digits_ctrl: RTL

- Score controller for the on-screen numbers display. Collects scoring events from game logic, keeps a saturating binary score, and converts it to BCD with a sequential double-dabble engine.
- Drives stable ones/tens/hundreds digit indices and leading-zero blanking enables to the digit bitmap blocks, which feed the numbers priority mux.
- Digit outputs never change mid-conversion.

---
 rtl/score_digits_if.sv | 29 ++
 rtl/score_digits_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/score_digits_if.sv
// Event inputs from game logic and score/digit outputs toward the digit bitmap blocks.
interface score_digits_if #(
    parameter int SCORE_W = 10
);
    logic               pelletEvent;
    logic               ghostEvent;
    logic               fruitEvent;
    logic               clearScore;
    logic [SCORE_W-1:0] scoreOut;
    logic [3:0]         onesDigit;
    logic [3:0]         tensDigit;
    logic [3:0]         hundredsDigit;
    logic               tensEnable;
    logic               hundredsEnable;
    logic               busy;
    logic               digitsUpdated;

    modport master (
        output pelletEvent, ghostEvent, fruitEvent, clearScore,
        input  scoreOut, onesDigit, tensDigit, hundredsDigit,
        input  tensEnable, hundredsEnable, busy, digitsUpdated
    );

    modport slave (
        input  pelletEvent, ghostEvent, fruitEvent, clearScore,
        output scoreOut, onesDigit, tensDigit, hundredsDigit,
        output tensEnable, hundredsEnable, busy, digitsUpdated
    );
endinterface

// File: rtl/score_digits_ctrl.sv
// Saturating score accumulator with a sequential double-dabble BCD converter;
// digit outputs only change in LOAD or on clearScore.
module score_digits_ctrl #(
    parameter int SCORE_W    = 10,
    parameter int SCORE_MAX  = 999,
    parameter int PELLET_PTS = 1,
    parameter int GHOST_PTS  = 10,
    parameter int FRUIT_PTS  = 50
) (
    input  logic           clk,
    input  logic           reset,
    score_digits_if.slave  bus
);
    localparam int WORK_W = 12 + SCORE_W;
    localparam int SUM_W  = SCORE_W + 8;
    localparam int BC_W   = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {IDLE, ADD, CONV, LOAD} state_t;

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]          ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
    logic                tens_en_q, tens_en_d, hund_en_q, hund_en_d;
    logic                busy_q, busy_d;
    logic                upd_q, upd_d;

    logic [2:0]          evt;
    logic [2:0]          dec;
    logic [2:0]          cnt_nz_q;
    logic [2:0]          cnt_nz_d;
    logic [SUM_W-1:0]    add_pts;
    logic [SUM_W-1:0]    sum;
    logic                clear;

    assign clear = bus.clearScore;
    assign evt   = {bus.fruitEvent, bus.ghostEvent, bus.pelletEvent};

    // One add-3-then-shift step over the {hundreds, tens, ones, binary} register.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int i = 0; i < 3; i++) begin
            if (t[SCORE_W + 4*i +: 4] >= 4'd5)
                t[SCORE_W + 4*i +: 4] = t[SCORE_W + 4*i +: 4] + 4'd3;
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    // Index 0 = pellet, 1 = ghost, 2 = fruit; fruit wins when several are pending.
    always_comb begin
        dec     = 3'b000;
        add_pts = '0;
        if (state_q == ADD) begin
            if (cnt_nz_q[2]) begin
                dec[2]  = 1'b1;
                add_pts = SUM_W'(FRUIT_PTS);
            end else if (cnt_nz_q[1]) begin
                dec[1]  = 1'b1;
                add_pts = SUM_W'(GHOST_PTS);
            end else if (cnt_nz_q[0]) begin
                dec[0]  = 1'b1;
                add_pts = SUM_W'(PELLET_PTS);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear)
                    cnt_d = 2'd0;
                else if (evt[gi] && !dec[gi]) begin
                    if (cnt_q != 2'd3)
                        cnt_d = cnt_q + 2'd1;
                end else if (!evt[gi] && dec[gi])
                    cnt_d = cnt_q - 2'd1;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_q <= 2'd0;
                else       cnt_q <= cnt_d;
            end

            assign cnt_nz_q[gi] = (cnt_q != 2'd0);
            assign cnt_nz_d[gi] = (cnt_d != 2'd0);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        work_d    = work_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        hund_d    = hund_q;
        tens_en_d = tens_en_q;
        hund_en_d = hund_en_q;
        upd_d     = 1'b0;
        sum       = {8'b0, score_q} + add_pts;

        case (state_q)
            IDLE: begin
                if (|cnt_nz_q) state_d = ADD;
            end
            ADD: begin
                if (sum > SUM_W'(SCORE_MAX)) score_d = SCORE_W'(SCORE_MAX);
                else                         score_d = sum[SCORE_W-1:0];
                if (!(|cnt_nz_d)) begin
                    state_d   = CONV;
                    work_d    = {12'b0, score_d};
                    bit_cnt_d = '0;
                end
            end
            CONV: begin
                work_d    = dabble_step(work_q);
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BC_W'(SCORE_W - 1)) state_d = LOAD;
            end
            LOAD: begin
                ones_d    = work_q[SCORE_W     +: 4];
                tens_d    = work_q[SCORE_W + 4 +: 4];
                hund_d    = work_q[SCORE_W + 8 +: 4];
                hund_en_d = (work_q[SCORE_W + 8 +: 4] != 4'd0);
                tens_en_d = (work_q[SCORE_W + 8 +: 4] != 4'd0) || (work_q[SCORE_W + 4 +: 4] != 4'd0);
                upd_d     = 1'b1;
                state_d   = (|cnt_nz_q) ? ADD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d   = IDLE;
            score_d   = '0;
            ones_d    = 4'd0;
            tens_d    = 4'd0;
            hund_d    = 4'd0;
            tens_en_d = 1'b0;
            hund_en_d = 1'b0;
            upd_d     = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            work_q    <= '0;
            bit_cnt_q <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            tens_en_q <= 1'b0;
            hund_en_q <= 1'b0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            work_q    <= work_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            tens_en_q <= tens_en_d;
            hund_en_q <= hund_en_d;
            busy_q    <= busy_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.scoreOut       = score_q;
    assign bus.onesDigit      = ones_q;
    assign bus.tensDigit      = tens_q;
    assign bus.hundredsDigit  = hund_q;
    assign bus.tensEnable     = tens_en_q;
    assign bus.hundredsEnable = hund_en_q;
    assign bus.busy           = busy_q;
    assign bus.digitsUpdated  = upd_q;
endmodule
